// File: rtl/can_pkg.sv
// Shared definitions for the CAN error/overload frame transmitter.
package can_pkg;

    localparam logic CAN_DOMINANT  = 1'b0;
    localparam logic CAN_RECESSIVE = 1'b1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CRC_WAIT = 3'd1,
        ERR_FLAG = 3'd2,
        OVL_FLAG = 3'd3,
        ECHO     = 3'd4,
        DELIM    = 3'd5,
        IFS      = 3'd6
    } err_tx_state_e;

endpackage

// File: rtl/can_flag_monitor.sv
// Counts consecutive equal bus samples. run_len is the length of the current
// run including the bit on this sample point; clear restarts counting so the
// next sample point begins a new run of length 1.
module can_flag_monitor #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_point,
    input  logic             clear,
    input  logic             rx_bit,
    output logic [CNT_W-1:0] run_len
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d;

    // Run length seen on this sample (saturates instead of wrapping)
    always_comb begin
        if (cnt_q == '0 || rx_bit != last_q) run_len = CNT_W'(1);
        else if (&cnt_q)                     run_len = cnt_q;
        else                                 run_len = cnt_q + CNT_W'(1);
    end

    // Commit the run on each sample point
    always_comb begin
        cnt_d  = cnt_q;
        last_d = last_q;
        if (sample_point) begin
            cnt_d  = clear ? '0 : run_len;
            last_d = rx_bit;
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            last_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/can_error_frame_tx.sv
// Error / overload frame transmitter: flag, echo, delimiter, intermission.
// Optional frame statistics counters are built when CAN_ERR_FRAME_STATS_EN
// is defined; otherwise err_frame_cnt / ovl_frame_cnt read as zero.
module can_error_frame_tx
    import can_pkg::*;
#(
    parameter int FLAG_LEN     = 6,
    parameter int DELIM_LEN    = 8,
    parameter int IFS_LEN      = 3,
    parameter int MAX_OVERLOAD = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sample_point,
    input  logic        rx_bit,
    input  logic        error_detected,
    input  logic        crc_error,
    input  logic        ack_delim_done,
    input  logic        overload_request,
    input  logic        error_passive,
    input  logic        bus_off,
    output logic        tx_bit,
    output logic        busy,
    output logic        dominant_after_flag,
    output logic        frame_restart,
    output logic [15:0] err_frame_cnt,
    output logic [15:0] ovl_frame_cnt
);

    localparam logic [3:0] FLAG_LAST  = 4'(FLAG_LEN - 1);
    localparam logic [3:0] FLAG_RUN   = 4'(FLAG_LEN);
    localparam logic [3:0] DELIM_LAST = 4'(DELIM_LEN - 1);
    localparam logic [3:0] IFS_LAST   = 4'(IFS_LEN - 1);
    localparam logic [3:0] OVL_MAX    = 4'(MAX_OVERLOAD);

    err_tx_state_e state_q, state_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [3:0]    ovl_cnt_q, ovl_cnt_d;
    logic          flag_val_q, flag_val_d;
    logic          daf_done_q, daf_done_d;
    logic          tx_bit_q, tx_bit_d;
    logic          busy_q, busy_d;
    logic          daf_q, daf_d;
    logic          restart_q, restart_d;
    logic [3:0]    flag_run;
    logic          mon_clear;

    // A fresh passive-flag run starts whenever ERR_FLAG is (re)entered
    assign mon_clear = (state_d == ERR_FLAG) && (state_q != ERR_FLAG);

    can_flag_monitor #(.CNT_W(4)) u_mon (
        .clk          (clk),
        .rst          (rst),
        .sample_point (sample_point),
        .clear        (mon_clear),
        .rx_bit       (rx_bit),
        .run_len      (flag_run)
    );

    // Frame sequencing; bus_off overrides everything, on any cycle
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        ovl_cnt_d  = ovl_cnt_q;
        flag_val_d = flag_val_q;
        daf_done_d = daf_done_q;
        daf_d      = 1'b0;
        restart_d  = 1'b0;
        if (bus_off) begin
            state_d    = IDLE;
            bit_cnt_d  = '0;
            ovl_cnt_d  = '0;
            daf_done_d = 1'b0;
        end else if (sample_point) begin
            case (state_q)
                IDLE: begin
                    if (!overload_request) ovl_cnt_d = '0;
                    if (error_detected) begin
                        state_d    = ERR_FLAG;
                        flag_val_d = error_passive;
                        bit_cnt_d  = '0;
                    end else if (crc_error) begin
                        state_d = CRC_WAIT;
                    end else if (overload_request && ovl_cnt_q < OVL_MAX) begin
                        state_d   = OVL_FLAG;
                        bit_cnt_d = '0;
                        ovl_cnt_d = ovl_cnt_q + 4'd1;
                    end
                end
                CRC_WAIT: begin
                    if (ack_delim_done || error_detected) begin
                        state_d    = ERR_FLAG;
                        flag_val_d = error_passive;
                        bit_cnt_d  = '0;
                    end
                end
                ERR_FLAG: begin
                    // passive flag ends on bus quiet, active flag on length
                    if (flag_val_q ? (flag_run == FLAG_RUN) : (bit_cnt_q == FLAG_LAST)) begin
                        state_d    = ECHO;
                        bit_cnt_d  = '0;
                        daf_done_d = 1'b0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
                OVL_FLAG: begin
                    if (bit_cnt_q == FLAG_LAST) begin
                        state_d    = ECHO;
                        bit_cnt_d  = '0;
                        daf_done_d = 1'b1;  // overload frames never pulse REC
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
                ECHO: begin
                    if (rx_bit == CAN_RECESSIVE) begin
                        state_d   = DELIM;
                        bit_cnt_d = 4'd1;
                    end else if (!daf_done_q) begin
                        daf_d      = 1'b1;
                        daf_done_d = 1'b1;
                    end
                end
                DELIM: begin
                    if (rx_bit == CAN_DOMINANT) begin
                        state_d    = ERR_FLAG;
                        flag_val_d = error_passive;
                        bit_cnt_d  = '0;
                    end else if (bit_cnt_q == DELIM_LAST) begin
                        state_d   = IFS;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
                IFS: begin
                    if (overload_request && bit_cnt_q < 4'd2 && ovl_cnt_q < OVL_MAX) begin
                        state_d   = OVL_FLAG;
                        bit_cnt_d = '0;
                        ovl_cnt_d = ovl_cnt_q + 4'd1;
                    end else if (bit_cnt_q == IFS_LAST) begin
                        state_d   = IDLE;
                        bit_cnt_d = '0;
                        restart_d = 1'b1;
                        if (!overload_request) ovl_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Registered outputs follow the next state so a transition shows one cycle later
    always_comb begin
        tx_bit_d = CAN_RECESSIVE;
        if (state_d == ERR_FLAG)      tx_bit_d = flag_val_d;
        else if (state_d == OVL_FLAG) tx_bit_d = CAN_DOMINANT;
        busy_d = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            ovl_cnt_q  <= '0;
            flag_val_q <= 1'b0;
            daf_done_q <= 1'b0;
            tx_bit_q   <= CAN_RECESSIVE;
            busy_q     <= 1'b0;
            daf_q      <= 1'b0;
            restart_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            ovl_cnt_q  <= ovl_cnt_d;
            flag_val_q <= flag_val_d;
            daf_done_q <= daf_done_d;
            tx_bit_q   <= tx_bit_d;
            busy_q     <= busy_d;
            daf_q      <= daf_d;
            restart_q  <= restart_d;
        end
    end

    assign tx_bit              = tx_bit_q;
    assign busy                = busy_q;
    assign dominant_after_flag = daf_q;
    assign frame_restart       = restart_q;

`ifdef CAN_ERR_FRAME_STATS_EN
    logic [15:0] err_fc_q, err_fc_d;
    logic [15:0] ovl_fc_q, ovl_fc_d;
    logic        err_entry, ovl_entry;

    assign err_entry = (state_d == ERR_FLAG) && (state_q != ERR_FLAG);
    assign ovl_entry = (state_d == OVL_FLAG) && (state_q != OVL_FLAG);

    // Saturating frame counters, cleared only by reset
    always_comb begin
        err_fc_d = err_fc_q;
        ovl_fc_d = ovl_fc_q;
        if (err_entry && err_fc_q != 16'hFFFF) err_fc_d = err_fc_q + 16'd1;
        if (ovl_entry && ovl_fc_q != 16'hFFFF) ovl_fc_d = ovl_fc_q + 16'd1;
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            err_fc_q <= '0;
            ovl_fc_q <= '0;
        end else begin
            err_fc_q <= err_fc_d;
            ovl_fc_q <= ovl_fc_d;
        end
    end

    assign err_frame_cnt = err_fc_q;
    assign ovl_frame_cnt = ovl_fc_q;
`else
    assign err_frame_cnt = 16'h0000;
    assign ovl_frame_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_can_error_frame_tx.sv
// Randomized frame-level bench: each scenario is laid out as per-bit stimulus
// and expected bus/pulse tables derived from frame timing arithmetic.
module tb_can_error_frame_tx;

    localparam int NB   = 128;
    localparam int FLAG = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sample_point = 1'b0, rx_bit = 1'b1, error_detected = 1'b0;
    logic crc_error = 1'b0, ack_delim_done = 1'b0, overload_request = 1'b0;
    logic error_passive = 1'b0, bus_off = 1'b0;
    logic tx_bit, busy, dominant_after_flag, frame_restart;
    logic [15:0] err_frame_cnt, ovl_frame_cnt;

    int n_cmp = 0, n_bad = 0;
    int exp_err = 0, exp_ovl = 0, ocnt = 0, n_bits = 0;

    bit s_rx[NB], s_err[NB], s_crc[NB], s_ack[NB], s_ovl[NB], s_pas[NB];
    bit e_tx[NB], e_busy[NB], e_daf[NB], e_rst[NB];

    always #5 clk = ~clk;

    can_error_frame_tx dut (
        .clk                 (clk),
        .rst                 (rst),
        .sample_point        (sample_point),
        .rx_bit              (rx_bit),
        .error_detected      (error_detected),
        .crc_error           (crc_error),
        .ack_delim_done      (ack_delim_done),
        .overload_request    (overload_request),
        .error_passive       (error_passive),
        .bus_off             (bus_off),
        .tx_bit              (tx_bit),
        .busy                (busy),
        .dominant_after_flag (dominant_after_flag),
        .frame_restart       (frame_restart),
        .err_frame_cnt       (err_frame_cnt),
        .ovl_frame_cnt       (ovl_frame_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_stats(input string tag);
`ifdef CAN_ERR_FRAME_STATS_EN
        chk({tag, " err_frame_cnt"}, 32'(err_frame_cnt), 32'(exp_err));
        chk({tag, " ovl_frame_cnt"}, 32'(ovl_frame_cnt), 32'(exp_ovl));
`else
        chk({tag, " err_frame_cnt"}, 32'(err_frame_cnt), 32'(0));
        chk({tag, " ovl_frame_cnt"}, 32'(ovl_frame_cnt), 32'(0));
`endif
    endtask

    // One bit time: inputs presented on a sample-point cycle, returns at the
    // falling edge right after the sampling edge
    task automatic step(input bit rx, input bit err, input bit crc, input bit ack,
                        input bit ovl, input bit pas);
        @(negedge clk);
        rx_bit = rx; error_detected = err; crc_error = crc; ack_delim_done = ack;
        overload_request = ovl; error_passive = pas; sample_point = 1'b1;
        @(negedge clk);
        sample_point = 1'b0; error_detected = 1'b0; crc_error = 1'b0;
        ack_delim_done = 1'b0; overload_request = 1'b0;
    endtask

    task automatic clear_plan();
        for (int k = 0; k < NB; k++) begin
            s_rx[k] = 1'b1; s_err[k] = 1'b0; s_crc[k] = 1'b0; s_ack[k] = 1'b0;
            s_ovl[k] = 1'b0; s_pas[k] = 1'($urandom);
            e_tx[k] = 1'b1; e_busy[k] = 1'b0; e_daf[k] = 1'b0; e_rst[k] = 1'b0;
        end
        n_bits = 0;
    endtask

    // Lay out one frame whose flag begins on the bit after sample s0.
    // e = dominant echo bits after the flag; tog = passive-flag toggle offset.
    // Returns d = sample index of delimiter bit 1.
    task automatic plan_frame(input int s0, input bit is_ovl, input bit pas,
                              input int e, input int tog, output int d);
        int  f, run;
        bit  done;
        f = s0 + FLAG; run = 0; done = 1'b0;
        if (is_ovl) exp_ovl++; else exp_err++;
        for (int k = s0 + 1; k <= s0 + 12; k++)
            s_rx[k] = (pas && !(tog != 0 && k >= s0 + tog)) ? 1'b1 : 1'b0;
        if (pas) begin
            for (int k = s0 + 1; k <= s0 + 12; k++) begin
                run = (k > s0 + 1 && s_rx[k] == s_rx[k-1]) ? run + 1 : 1;
                if (!done && run == FLAG) begin f = k; done = 1'b1; end
            end
        end
        for (int k = s0; k < f; k++) begin
            e_tx[k] = pas; e_busy[k] = 1'b1; e_daf[k] = 1'b0; e_rst[k] = 1'b0;
        end
        for (int k = f; k <= f + e; k++) begin
            if (k > f) s_rx[k] = 1'b0;
            e_tx[k] = 1'b1; e_busy[k] = 1'b1; e_rst[k] = 1'b0;
            e_daf[k] = (k == f + 1) && !is_ovl;
        end
        d = f + e + 1;
        for (int k = d; k <= d + 10; k++) begin
            s_rx[k] = 1'b1; e_tx[k] = 1'b1; e_daf[k] = 1'b0;
            e_busy[k] = (k < d + 10); e_rst[k] = (k == d + 10);
        end
        n_bits = d + 13;
    endtask

    task automatic run_plan(input int kind);
        for (int k = 0; k < n_bits; k++) begin
            step(s_rx[k], s_err[k], s_crc[k], s_ack[k], s_ovl[k], s_pas[k]);
            chk($sformatf("s%0d tx[%0d]", kind, k), 32'(tx_bit), 32'(e_tx[k]));
            chk($sformatf("s%0d busy[%0d]", kind, k), 32'(busy), 32'(e_busy[k]));
            chk($sformatf("s%0d daf[%0d]", kind, k), 32'(dominant_after_flag), 32'(e_daf[k]));
            chk($sformatf("s%0d restart[%0d]", kind, k), 32'(frame_restart), 32'(e_rst[k]));
            @(negedge clk);
            chk($sformatf("s%0d pulse_clr[%0d]", kind, k),
                32'({dominant_after_flag, frame_restart}), 32'(0));
        end
        chk_stats($sformatf("s%0d", kind));
    endtask

    int kind, e, tog, d, g, p;
    bit pas, pas2, stop;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst tx", 32'(tx_bit), 32'(1));
        chk("rst busy", 32'(busy), 32'(0));
        chk("rst pulses", 32'({dominant_after_flag, frame_restart}), 32'(0));
        chk_stats("rst");
        rst = 1'b0;

        for (int it = 0; it < 30; it++) begin
            kind = $urandom_range(0, 3);
            pas  = 1'($urandom);
            e    = $urandom_range(0, 3);
            tog  = $urandom_range(0, 6);
            clear_plan();
            ocnt = 0;
            case (kind)
                0: begin  // error frame; lower-priority triggers and ignored errors mixed in
                    s_err[0] = 1'b1; s_pas[0] = pas;
                    s_crc[0] = 1'($urandom); s_ovl[0] = 1'($urandom);
                    plan_frame(0, 1'b0, pas, e, tog, d);
                    for (int k = 1; k <= 5; k++) begin
                        s_err[k] = 1'($urandom); s_crc[k] = 1'($urandom);
                    end
                end
                1: begin  // deferred CRC flag
                    g = $urandom_range(1, 3);
                    s_crc[0] = 1'b1; s_ovl[0] = 1'($urandom);
                    for (int k = 0; k < g; k++) begin
                        e_tx[k] = 1'b1; e_busy[k] = 1'b1;
                        if (k > 0) begin s_crc[k] = 1'($urandom); s_ovl[k] = 1'($urandom); end
                    end
                    if ($urandom_range(0, 1) == 1) s_ack[g] = 1'b1; else s_err[g] = 1'b1;
                    s_pas[g] = pas;
                    plan_frame(g, 1'b0, pas, e, tog, d);
                end
                2: begin  // overload requests in IFS until the limit
                    if ($urandom_range(0, 1) == 1) begin
                        s_ovl[0] = 1'b1;
                        plan_frame(0, 1'b1, 1'b0, e, 0, d);
                        ocnt = 1;
                    end else begin
                        s_err[0] = 1'b1; s_pas[0] = pas;
                        plan_frame(0, 1'b0, pas, e, tog, d);
                    end
                    stop = 1'b0;
                    for (int r = 0; r < 4; r++) begin
                        if (!stop) begin
                            p = d + 8 + $urandom_range(0, 1);
                            s_ovl[p] = 1'b1;
                            if (ocnt < 2) begin
                                ocnt++;
                                plan_frame(p, 1'b1, 1'b0, $urandom_range(0, 3), 0, d);
                            end else begin
                                stop = 1'b1;
                            end
                        end
                    end
                end
                default: begin  // dominant bit inside the delimiter
                    s_err[0] = 1'b1; s_pas[0] = pas;
                    plan_frame(0, 1'b0, pas, e, tog, d);
                    p = d + $urandom_range(2, 8) - 1;
                    pas2 = 1'($urandom);
                    s_rx[p] = 1'b0; s_pas[p] = pas2;
                    plan_frame(p, 1'b0, pas2, $urandom_range(0, 3), $urandom_range(0, 6), d);
                end
            endcase
            run_plan(kind);
        end

        // bus_off in the middle of an active flag, then triggers while held
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_err++;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("boff pre tx", 32'(tx_bit), 32'(0));
        chk("boff pre busy", 32'(busy), 32'(1));
        bus_off = 1'b1;
        @(negedge clk);
        chk("boff tx", 32'(tx_bit), 32'(1));
        chk("boff busy", 32'(busy), 32'(0));
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("boff held busy", 32'(busy), 32'(0));
        chk("boff held tx", 32'(tx_bit), 32'(1));
        bus_off = 1'b0;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("boff rel busy", 32'(busy), 32'(0));
        chk_stats("boff");

        // reset in the middle of the delimiter
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 9; k++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("delim busy", 32'(busy), 32'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_err = 0; exp_ovl = 0;
        chk("midrst tx", 32'(tx_bit), 32'(1));
        chk("midrst busy", 32'(busy), 32'(0));
        chk("midrst pulses", 32'({dominant_after_flag, frame_restart}), 32'(0));
        chk_stats("midrst");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("midrst idle busy", 32'(busy), 32'(0));
        chk("midrst idle restart", 32'(frame_restart), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
